scan_test_ctrl: RTL and testbench
=================================

Name: scan_test_ctrl

Overview:
- Sequences the scan chain of the c4 datapath (scan flops plus output register, chain SDI→s→t→n→SDO) through a full structural test.
- On `start`, it shifts a test vector in with scan mode asserted, then drops mode for one functional capture cycle, then shifts the captured state out.
- It compares the unloaded bits against a masked expected vector and reports pass/fail with a saturating failure count.
- It sits beside the datapath. It drives the datapath's mode and serial-in pins and observes its serial-out pin.

Parameters:
- CHAIN_LEN, 3, number of scan elements in the chain (≥2). Position 0 is the SDI side; position CHAIN_LEN-1 is the SDO side.
- CNT_W, 8, width of the failure counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (rst=0 resets).
- start  input  1  single-cycle request to run one test; sampled only in IDLE.
- vec_in  input  CHAIN_LEN  stimulus; bit i is loaded into chain position i.
- exp_in  input  CHAIN_LEN  expected captured state; bit i corresponds to position i.
- mask_in  input  CHAIN_LEN  1 = compare this bit, 0 = don't care.
- sdo  input  1  serial out of the chain.
- m  output  1  scan mode to the chain; 1 = shift, 0 = functional capture.
- sdi  output  1  serial in to the chain.
- busy  output  1  high from the cycle after start is accepted until DONE is exited.
- done  output  1  single-cycle pulse; result is valid.
- pass  output  1  result of the last completed test; held until the next done.
- captured  output  CHAIN_LEN  unloaded chain state; bit i = position i.
- fail_count  output  CNT_W  number of failed tests since reset; saturates at all-ones.

Behaviour:

Reset (rst=0, any time, mid-operation included):
- state=IDLE; m=0, sdi=0, busy=0, done=0, pass=0, captured=0, fail_count=0.
- The bit counter is cleared.
- No partial result is reported.

Registered outputs:
- m, sdi, busy and done are all registered; no combinational path from any input.

States: IDLE, SHIFT_IN, CAPTURE, SHIFT_OUT, DONE.

IDLE:
- m=0, sdi=0.
- On start=1: latch vec_in, exp_in and mask_in into internal registers; clear bit counter k; go to SHIFT_IN.
- Input changes after acceptance have no effect on the run.

SHIFT_IN (exactly CHAIN_LEN cycles):
- m=1.
- At count k (0..CHAIN_LEN-1), sdi = vec[CHAIN_LEN-1-k]; the last-position bit is sent first.
- After the cycle with k=CHAIN_LEN-1, go to CAPTURE.

CAPTURE (exactly 1 cycle):
- m=0, sdi=0; the chain performs one functional clock.
- Then clear k and go to SHIFT_OUT.

SHIFT_OUT (exactly CHAIN_LEN cycles):
- m=1, sdi=0 (zero fill).
- At each rising edge ending count k, sample sdo into captured[CHAIN_LEN-1-k].
- After k=CHAIN_LEN-1, go to DONE.

DONE (1 cycle):
- m=0; done=1.
- pass = ((captured ^ exp) & mask) == 0; captured is the complete register here.
- If pass=0 and fail_count is not all-ones, fail_count increments by 1.
- Then go to IDLE; busy drops in the same cycle that done falls.

Run timing:
- Total run = 2·CHAIN_LEN + 2 cycles from start acceptance to the done pulse.
- start asserted while busy=1 or during DONE is ignored and is not queued.
- start in the same cycle that DONE is exited back to IDLE is not accepted; it must be presented in IDLE.

Boundary cases:
- mask_in all-zero → pass=1 regardless of data.
- fail_count at all-ones with another failure → stays all-ones.
- rst asserted during SHIFT_OUT → captured=0 and no done pulse.

Test Plan:
- Reset during SHIFT_IN (cycle 1) → m=0, busy=0, state IDLE next cycle, no done pulse; a following start runs a clean full sequence.
- CHAIN_LEN=3, chain modelled as a pure shift register (capture = hold), vec_in=3'b101, exp=3'b101, mask=3'b111 → sdi stream 1,0,1; m pattern 1,1,1,0,1,1,1; done at cycle 8 after start; captured=101; pass=1; fail_count=0.
- Same run with exp=3'b100, mask=3'b111 → pass=0, fail_count=1. Repeat with mask=3'b110 → pass=1, fail_count stays 1.
- start pulsed during SHIFT_OUT and again in the DONE cycle → both ignored; exactly one done pulse.
- Force 255 consecutive failures with CNT_W=8, then one more → fail_count=255 after both.
- Capture check with a real c4 instance: chain preloaded s=0, t=1, n via vec_in; capture with a=1, c=0 → captured equals next_state/output_reg values computed by the reference model for that input.

Source files
------------

// File: rtl/scan_test_ctrl_if.sv
// ----------------------------------------------------------------------------
// scan_test_ctrl_if
//   Bundles the test request and result bus of scan_test_ctrl together with the
//   three scan pins it shares with the datapath chain.
//
//   Request : start, vec_in, exp_in, mask_in
//   Chain   : m (mode, 1 = shift), sdi (serial in), sdo (serial out)
//   Result  : busy, done, pass, captured, fail_count
//
//   slave  : the controller side (drives m/sdi and the results)
//   master : requester plus chain side (drives the request and sdo)
// ----------------------------------------------------------------------------
interface scan_test_ctrl_if #(
    parameter int CHAIN_LEN = 3,
    parameter int CNT_W     = 8
);
    logic                 start;
    logic [CHAIN_LEN-1:0] vec_in;
    logic [CHAIN_LEN-1:0] exp_in;
    logic [CHAIN_LEN-1:0] mask_in;
    logic                 sdo;
    logic                 m;
    logic                 sdi;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CHAIN_LEN-1:0] captured;
    logic [CNT_W-1:0]     fail_count;

    modport slave (
        input  start, vec_in, exp_in, mask_in, sdo,
        output m, sdi, busy, done, pass, captured, fail_count
    );

    modport master (
        output start, vec_in, exp_in, mask_in, sdo,
        input  m, sdi, busy, done, pass, captured, fail_count
    );
endinterface

// File: rtl/scan_test_ctrl.sv
// ----------------------------------------------------------------------------
// scan_test_ctrl
//   Runs one structural test of a scan chain per start request:
//   shift a stimulus in (m=1), one functional capture (m=0), shift the
//   captured state out with zero fill, then compare against a masked
//   expected vector. Chain position 0 is the SDI side, CHAIN_LEN-1 the SDO
//   side, so the last-position bit is shifted in first and appears on sdo
//   first when unloading.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous reset, active low
//     bus  - scan_test_ctrl_if.slave (request, scan pins, results)
//
//   All outputs are registered. A run takes 2*CHAIN_LEN+2 cycles from the
//   accepting edge to the done pulse; start is only looked at in IDLE.
// ----------------------------------------------------------------------------
module scan_test_ctrl #(
    parameter int CHAIN_LEN = 3,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    scan_test_ctrl_if.slave    bus
);

    localparam int K_W = (CHAIN_LEN > 2) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } state_t;

    state_t               state;
    logic [K_W-1:0]       k;
    logic [CHAIN_LEN-1:0] vec_q;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;
    logic [CHAIN_LEN-1:0] cap_q;
    logic [CNT_W-1:0]     fail_q;
    logic                 m_q;
    logic                 sdi_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;

    // Bit index helpers: the stream runs from position CHAIN_LEN-1 down to 0.
    logic [K_W-1:0]       k_nx;
    logic [K_W-1:0]       in_idx;
    logic [K_W-1:0]       out_idx;
    logic [CHAIN_LEN-1:0] cap_next;
    logic                 pass_next;

    assign k_nx    = k + K_W'(1);
    assign in_idx  = K_LAST - k_nx;   // bit driven on sdi during the next cycle
    assign out_idx = K_LAST - k;      // bit arriving on sdo at this edge

    // The compare in the last SHIFT_OUT cycle needs the final bit too, so it
    // works on the register value as it will be after this edge.
    always_comb begin
        cap_next          = cap_q;
        cap_next[out_idx] = bus.sdo;
    end

    assign pass_next = (((cap_next ^ exp_q) & mask_q) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            k      <= '0;
            vec_q  <= '0;
            exp_q  <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            fail_q <= '0;
            m_q    <= 1'b0;
            sdi_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    m_q   <= 1'b0;
                    sdi_q <= 1'b0;
                    if (bus.start) begin
                        vec_q  <= bus.vec_in;
                        exp_q  <= bus.exp_in;
                        mask_q <= bus.mask_in;
                        k      <= '0;
                        // First shift cycle starts right away with the
                        // last-position bit already on sdi.
                        m_q    <= 1'b1;
                        sdi_q  <= bus.vec_in[CHAIN_LEN-1];
                        busy_q <= 1'b1;
                        state  <= SHIFT_IN;
                    end
                end
                SHIFT_IN: begin
                    if (k == K_LAST) begin
                        m_q   <= 1'b0;
                        sdi_q <= 1'b0;
                        state <= CAPTURE;
                    end else begin
                        k     <= k_nx;
                        sdi_q <= vec_q[in_idx];
                    end
                end
                CAPTURE: begin
                    k     <= '0;
                    m_q   <= 1'b1;
                    sdi_q <= 1'b0;
                    state <= SHIFT_OUT;
                end
                SHIFT_OUT: begin
                    cap_q <= cap_next;
                    if (k == K_LAST) begin
                        m_q    <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= pass_next;
                        if (!pass_next && (fail_q != '1))
                            fail_q <= fail_q + CNT_W'(1);
                        state  <= DONE;
                    end else begin
                        k <= k_nx;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m          = m_q;
    assign bus.sdi        = sdi_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.captured   = cap_q;
    assign bus.fail_count = fail_q;

endmodule

// File: tb/tb_scan_test_ctrl.sv
// ----------------------------------------------------------------------------
// tb_scan_test_ctrl
//   Directed bench for scan_test_ctrl with CHAIN_LEN=3, CNT_W=8. The chain is
//   a 3-bit shift register (chain[0]=s at SDI, chain[2]=n at SDO). With use_c4
//   clear it holds when m=0; with use_c4 set it takes a c4-style functional
//   step: s' = a ^ t, t' = s | a, n' = t & ~c.
// ----------------------------------------------------------------------------
module tb_scan_test_ctrl;

    localparam int N  = 3;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    scan_test_ctrl_if #(.CHAIN_LEN(N), .CNT_W(CW)) bus();

    scan_test_ctrl #(.CHAIN_LEN(N), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [N-1:0] chain  = '0;
    logic         use_c4 = 1'b0;
    logic         c4_a   = 1'b0;
    logic         c4_c   = 1'b0;

    assign bus.sdo = chain[N-1];

    always @(posedge clk) begin
        if (bus.m)
            chain <= {chain[N-2:0], bus.sdi};
        else if (use_c4)
            chain <= {chain[1] & ~c4_c, chain[0] | c4_a, c4_a ^ chain[1]};
    end

    int vecs = 0;
    int errs = 0;

    // Results of one run, filled by do_run.
    int             done_cyc, done_cnt, busy_cnt;
    logic [6:0]     m_seq;
    logic [2:0]     sdi_seq;
    logic           pass_d;
    logic [N-1:0]   cap_d;
    logic [CW-1:0]  fc_d;

    // Launch one test and observe cycles 1..20 after the accepting edge.
    // Extra start pulses are driven in cycles xa and xb (0 = none).
    task automatic do_run(input logic [N-1:0] v, input logic [N-1:0] e,
                          input logic [N-1:0] mk, input int xa, input int xb);
        @(negedge clk);
        bus.vec_in  = v;
        bus.exp_in  = e;
        bus.mask_in = mk;
        bus.start   = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.vec_in  = ~v;
        bus.exp_in  = ~e;
        bus.mask_in = ~mk;
        done_cyc = 0; done_cnt = 0; busy_cnt = 0;
        m_seq = '0; sdi_seq = '0; pass_d = 1'bx; cap_d = 'x; fc_d = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = (c == xa || c == xb);
            if (c <= 7) m_seq[c-1]   = bus.m;
            if (c <= 3) sdi_seq[c-1] = bus.sdi;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc = c;
                    pass_d   = bus.pass;
                    cap_d    = bus.captured;
                    fc_d     = bus.fail_count;
                end
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        bus.start = 0; bus.vec_in = '0; bus.exp_in = '0; bus.mask_in = '0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vecs++; if (bus.m !== 1'b0) begin errs++; $display("FAIL reset_m: got %b want 0", bus.m); end
        vecs++; if (bus.sdi !== 1'b0) begin errs++; $display("FAIL reset_sdi: got %b want 0", bus.sdi); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        vecs++; if (bus.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vecs++; if (bus.pass !== 1'b0) begin errs++; $display("FAIL reset_pass: got %b want 0", bus.pass); end
        vecs++; if (bus.captured !== 3'b000) begin errs++; $display("FAIL reset_captured: got %b want 000", bus.captured); end
        vecs++; if (bus.fail_count !== 8'd0) begin errs++; $display("FAIL reset_fail_count: got %0d want 0", bus.fail_count); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_shift_in;
        int dn, bz;
        @(negedge clk);
        bus.vec_in = 3'b101; bus.exp_in = 3'b101; bus.mask_in = 3'b111;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        vecs++; if (bus.m !== 1'b1) begin errs++; $display("FAIL rstin_m_before: got %b want 1", bus.m); end
        #1 rst = 1'b0;
        #1;
        vecs++; if (bus.m !== 1'b0) begin errs++; $display("FAIL rstin_m: got %b want 0", bus.m); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rstin_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        rst = 1'b1;
        dn = 0; bz = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
            if (bus.busy || bus.m) bz++;
        end
        vecs++; if (dn !== 0) begin errs++; $display("FAIL rstin_no_done: got %0d pulses want 0", dn); end
        vecs++; if (bz !== 0) begin errs++; $display("FAIL rstin_idle: got %0d busy/m cycles want 0", bz); end
    endtask

    task automatic test_basic;
        do_run(3'b101, 3'b101, 3'b111, 0, 0);
        vecs++; if (sdi_seq !== 3'b101) begin errs++; $display("FAIL basic_sdi_stream: got %b want 101", sdi_seq); end
        vecs++; if (m_seq !== 7'b1110111) begin errs++; $display("FAIL basic_m_pattern: got %b want 1110111", m_seq); end
        vecs++; if (done_cyc !== 8) begin errs++; $display("FAIL basic_done_cycle: got %0d want 8", done_cyc); end
        vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
        vecs++; if (busy_cnt !== 8) begin errs++; $display("FAIL basic_busy_cycles: got %0d want 8", busy_cnt); end
        vecs++; if (cap_d !== 3'b101) begin errs++; $display("FAIL basic_captured: got %b want 101", cap_d); end
        vecs++; if (pass_d !== 1'b1) begin errs++; $display("FAIL basic_pass: got %b want 1", pass_d); end
        vecs++; if (fc_d !== 8'd0) begin errs++; $display("FAIL basic_fail_count: got %0d want 0", fc_d); end
    endtask

    task automatic test_compare;
        do_run(3'b101, 3'b100, 3'b111, 0, 0);
        vecs++; if (pass_d !== 1'b0) begin errs++; $display("FAIL cmp_mismatch_pass: got %b want 0", pass_d); end
        vecs++; if (fc_d !== 8'd1) begin errs++; $display("FAIL cmp_mismatch_count: got %0d want 1", fc_d); end
        vecs++; if (bus.pass !== 1'b0) begin errs++; $display("FAIL cmp_pass_held: got %b want 0", bus.pass); end
        do_run(3'b101, 3'b100, 3'b110, 0, 0);
        vecs++; if (pass_d !== 1'b1) begin errs++; $display("FAIL cmp_masked_pass: got %b want 1", pass_d); end
        vecs++; if (fc_d !== 8'd1) begin errs++; $display("FAIL cmp_masked_count: got %0d want 1", fc_d); end
        do_run(3'b011, 3'b100, 3'b000, 0, 0);
        vecs++; if (pass_d !== 1'b1) begin errs++; $display("FAIL cmp_mask_zero_pass: got %b want 1", pass_d); end
        vecs++; if (cap_d !== 3'b011) begin errs++; $display("FAIL cmp_mask_zero_captured: got %b want 011", cap_d); end
        vecs++; if (fc_d !== 8'd1) begin errs++; $display("FAIL cmp_mask_zero_count: got %0d want 1", fc_d); end
    endtask

    task automatic test_ignore_start;
        do_run(3'b110, 3'b110, 3'b111, 6, 8);
        vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
        vecs++; if (busy_cnt !== 8) begin errs++; $display("FAIL ign_busy_cycles: got %0d want 8", busy_cnt); end
        vecs++; if (done_cyc !== 8) begin errs++; $display("FAIL ign_done_cycle: got %0d want 8", done_cyc); end
        vecs++; if (cap_d !== 3'b110) begin errs++; $display("FAIL ign_captured: got %b want 110", cap_d); end
        vecs++; if (pass_d !== 1'b1) begin errs++; $display("FAIL ign_pass: got %b want 1", pass_d); end
    endtask

    task automatic test_reset_shift_out;
        int dn;
        @(negedge clk);
        bus.vec_in = 3'b111; bus.exp_in = 3'b111; bus.mask_in = 3'b111;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(negedge clk);          // cycle 6: inside SHIFT_OUT
        vecs++; if (bus.m !== 1'b1) begin errs++; $display("FAIL rstout_in_shift: got m=%b want 1", bus.m); end
        rst = 1'b0;
        #1;
        vecs++; if (bus.captured !== 3'b000) begin errs++; $display("FAIL rstout_captured: got %b want 000", bus.captured); end
        vecs++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rstout_busy: got %b want 0", bus.busy); end
        vecs++; if (bus.fail_count !== 8'd0) begin errs++; $display("FAIL rstout_fail_count: got %0d want 0", bus.fail_count); end
        @(negedge clk);
        rst = 1'b1;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        vecs++; if (dn !== 0) begin errs++; $display("FAIL rstout_no_done: got %0d pulses want 0", dn); end
    endtask

    task automatic test_c4_capture;
        use_c4 = 1'b1; c4_a = 1'b1; c4_c = 1'b0;
        // preload s=0, t=1, n=0; step gives s'=0, t'=1, n'=1
        do_run(3'b010, 3'b110, 3'b111, 0, 0);
        use_c4 = 1'b0;
        vecs++; if (cap_d !== 3'b110) begin errs++; $display("FAIL c4_captured: got %b want 110", cap_d); end
        vecs++; if (pass_d !== 1'b1) begin errs++; $display("FAIL c4_pass: got %b want 1", pass_d); end
    endtask

    task automatic test_saturate;
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 255; i++) do_run(3'b000, 3'b111, 3'b111, 0, 0);
        vecs++; if (fc_d !== 8'd255) begin errs++; $display("FAIL sat_255: got %0d want 255", fc_d); end
        vecs++; if (pass_d !== 1'b0) begin errs++; $display("FAIL sat_pass: got %b want 0", pass_d); end
        do_run(3'b000, 3'b111, 3'b111, 0, 0);
        vecs++; if (fc_d !== 8'd255) begin errs++; $display("FAIL sat_hold: got %0d want 255", fc_d); end
        vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL sat_done_count: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset;
        test_reset_shift_in;
        test_basic;
        test_compare;
        test_ignore_start;
        test_reset_shift_out;
        test_c4_capture;
        test_saturate;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
